// File: rtl/mem_sched_pkg.sv
// Shared definitions for the unified memory scheduler.
//   - FSM state encodings (2-bit, kept as plain localparams)
//   - default bubble instruction (add x0,x0,x0)
//   - RV32 load/store func3 codes
package mem_sched_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0033;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/access_timer.sv
// Memory access timer.
//   Down-counter loaded with MEM_LAT-1 when an access is granted; `last`
//   flags the final cycle of the access (count reached zero while active).
// Ports:
//   clk    in  core clock
//   rst_n  in  synchronous reset, active-low
//   start  in  access granted this cycle (reloads the counter)
//   active in  an access is currently in progress
//   last   out current cycle is the final cycle of the access
module access_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    output logic last
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LOAD;
        end else if (active && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = active && (cnt_q == '0);

endmodule

// File: rtl/unified_mem_scheduler.sv
// Unified I/D memory scheduler for the 5-stage RV32 pipeline.
//   Arbitrates the single memory between fetch (IF) and load/store (MEM),
//   returns instruction/load data with one-cycle valid pulses and drives the
//   pipeline stall signals.
// Ports:
//   CLK, RST                     core clock, synchronous active-low reset
//   if_req/if_addr/if_flush      fetch request, PC, fetch cancel
//   if_rdata/if_valid/if_stall   instruction (NOP when not valid), pulse, stall
//   dm_rd/dm_wr/dm_addr/...      load/store request from MEM stage
//   dm_rdata/dm_done/dm_stall    load data, completion pulse, stall
//   mem_*                        memory interface
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no access in progress, arbitrate each cycle
// ST_BUSY_IF | fetch access in progress (MEM_LAT cycles)
// ST_BUSY_DM | load/store access in progress (MEM_LAT cycles)
module unified_mem_scheduler
    import mem_sched_pkg::*;
#(
    parameter int          MEM_LAT    = 1,
    parameter int          STARVE_MAX = 3,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_func3,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata
);

    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic [1:0]      state_q, state_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            cancel_q, cancel_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      func3_q, func3_d;
    logic            we_q, we_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_done_q, dm_done_d;
    logic [31:0]     if_data_q, if_data_d;
    logic [31:0]     dm_data_q, dm_data_d;

    logic last, busy_if, busy_dm, arb_ok, dm_pend;
    logic grant_dm, grant_if, fetch_ok;

    access_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk    (CLK),
        .rst_n  (RST),
        .start  (grant_dm | grant_if),
        .active (state_q != ST_IDLE),
        .last   (last)
    );

    always_comb begin
        busy_if = (state_q == ST_BUSY_IF);
        busy_dm = (state_q == ST_BUSY_DM);
        // Arbitrating on the last busy cycle gives back-to-back accesses.
        arb_ok  = (state_q == ST_IDLE) | last;
        dm_pend = dm_rd | dm_wr;

        grant_dm = arb_ok & dm_pend & ((starve_q < STARVE_LIM) | ~if_req);
        grant_if = arb_ok & ~grant_dm & if_req & ~if_flush;
        // A flush on the final fetch cycle also suppresses the result.
        fetch_ok = busy_if & last & ~cancel_q & ~if_flush;

        state_d = state_q;
        if (grant_dm) begin
            state_d = ST_BUSY_DM;
        end else if (grant_if) begin
            state_d = ST_BUSY_IF;
        end else if (last) begin
            state_d = ST_IDLE;
        end

        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = '0;
        end else if (grant_dm && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SC_W'(1);
        end

        cancel_d = busy_if & ~last & (cancel_q | if_flush);

        addr_d  = addr_q;
        wdata_d = wdata_q;
        func3_d = func3_q;
        we_d    = we_q;
        if (grant_dm) begin
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            func3_d = dm_func3;
            we_d    = dm_wr;        // rd & wr together is a store
        end else if (grant_if) begin
            addr_d  = if_addr;
            wdata_d = '0;
            func3_d = F3_LW;
            we_d    = 1'b0;
        end

        if_valid_d = fetch_ok;
        dm_done_d  = busy_dm & last;
        if_data_d  = fetch_ok ? mem_rdata : if_data_q;
        dm_data_d  = (busy_dm & last) ? mem_rdata : dm_data_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            cancel_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            func3_q    <= '0;
            we_q       <= 1'b0;
            if_valid_q <= 1'b0;
            dm_done_q  <= 1'b0;
            if_data_q  <= NOP_INSTR;
            dm_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            cancel_q   <= cancel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            func3_q    <= func3_d;
            we_q       <= we_d;
            if_valid_q <= if_valid_d;
            dm_done_q  <= dm_done_d;
            if_data_q  <= if_data_d;
            dm_data_q  <= dm_data_d;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_valid_q ? if_data_q : NOP_INSTR;
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_data_q;
    assign dm_stall  = (dm_rd | dm_wr) & ~dm_done_q;
    assign mem_en    = (state_q != ST_IDLE);
    assign mem_we    = busy_dm & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_func3 = func3_q;

endmodule

// File: tb/tb_unified_mem_scheduler.sv
module tb_unified_mem_scheduler;

    localparam logic [31:0] NOP    = 32'h0000_0033;
    localparam int          STARVE = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req, if_flush, dm_rd, dm_wr;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [2:0]  dm_func3;

    logic [31:0] ifr1, dmr1, ad1, wd1, mr1;
    logic        ifv1, ifs1, dmd1, dms1, en1, we1;
    logic [2:0]  f31;
    logic [31:0] ifr3, dmr3, ad3, wd3, mr3;
    logic        ifv3, ifs3, dmd3, dms3, en3, we3;
    logic [2:0]  f33;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    // Memory contents: address 0 holds addi x1,x0,5; others derive from address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    assign mr1 = mem_fn(ad1);
    assign mr3 = mem_fn(ad3);

    unified_mem_scheduler #(.MEM_LAT(1), .STARVE_MAX(STARVE)) u1 (
        .CLK(CLK), .RST(RST), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(ifr1), .if_valid(ifv1), .if_stall(ifs1),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_func3(dm_func3),
        .dm_rdata(dmr1), .dm_done(dmd1), .dm_stall(dms1),
        .mem_en(en1), .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1), .mem_func3(f31),
        .mem_rdata(mr1)
    );

    unified_mem_scheduler #(.MEM_LAT(3), .STARVE_MAX(STARVE)) u3 (
        .CLK(CLK), .RST(RST), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(ifr3), .if_valid(ifv3), .if_stall(ifs3),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_func3(dm_func3),
        .dm_rdata(dmr3), .dm_done(dmd3), .dm_stall(dms3),
        .mem_en(en3), .mem_we(we3), .mem_addr(ad3), .mem_wdata(wd3), .mem_func3(f33),
        .mem_rdata(mr3)
    );

    // Behavioural model: who owns the memory and how many cycles remain.
    typedef struct {
        int          owner;     // 0 none, 1 fetch, 2 data
        int          rem;       // cycles left in current access, incl. this one
        int          starve;
        bit          canc;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic [2:0]  a_f3;
        bit          a_we;
        bit          ifv;
        bit          dmd;
        logic [31:0] ifdat;
        logic [31:0] dmdat;
    } model_t;

    model_t m1, m3;

    function automatic model_t step(input model_t m, input int lat);
        model_t n = m;
        bit fin, free, dmp;
        if (!RST) begin
            n.owner = 0; n.rem = 0; n.starve = 0; n.canc = 0;
            n.a_addr = '0; n.a_wdata = '0; n.a_f3 = '0; n.a_we = 0;
            n.ifv = 0; n.dmd = 0; n.ifdat = NOP; n.dmdat = '0;
            return n;
        end
        fin  = (m.owner != 0) && (m.rem == 1);
        free = (m.owner == 0) || fin;
        dmp  = dm_rd || dm_wr;
        n.ifv = (m.owner == 1) && fin && !m.canc && !if_flush;
        if (n.ifv) n.ifdat = mem_fn(m.a_addr);
        n.dmd = (m.owner == 2) && fin;
        if (n.dmd) n.dmdat = mem_fn(m.a_addr);
        n.canc = (m.owner == 1 && !fin) ? (m.canc || if_flush) : 1'b0;
        if (m.owner != 0) n.rem = m.rem - 1;
        if (fin) n.owner = 0;
        if (free) begin
            if (dmp && (m.starve < STARVE || !if_req)) begin
                n.owner = 2; n.rem = lat;
                n.a_addr = dm_addr; n.a_wdata = dm_wdata; n.a_f3 = dm_func3; n.a_we = dm_wr;
                if (if_req) n.starve = (m.starve < STARVE) ? m.starve + 1 : STARVE;
            end else if (if_req && !if_flush) begin
                n.owner = 1; n.rem = lat;
                n.a_addr = if_addr; n.a_wdata = '0; n.a_f3 = 3'b010; n.a_we = 0;
                n.starve = 0;
            end
        end
        if (!if_req) n.starve = 0;
        return n;
    endfunction

    always @(posedge CLK) begin
        m1 <= step(m1, 1);
        m3 <= step(m3, 3);
        if (!RST) chk_en <= 1'b1;
    end

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input model_t m,
                              input logic ifv, input logic [31:0] ifr, input logic ifs,
                              input logic dmd, input logic [31:0] dmr, input logic dms,
                              input logic en, input logic we, input logic [31:0] ad,
                              input logic [31:0] wd, input logic [2:0] f3);
        cmp({tag, ".if_valid"}, {31'b0, ifv}, {31'b0, m.ifv});
        cmp({tag, ".if_rdata"}, ifr, m.ifv ? m.ifdat : NOP);
        cmp({tag, ".if_stall"}, {31'b0, ifs}, {31'b0, if_req & ~m.ifv});
        cmp({tag, ".dm_done"},  {31'b0, dmd}, {31'b0, m.dmd});
        cmp({tag, ".dm_rdata"}, dmr, m.dmdat);
        cmp({tag, ".dm_stall"}, {31'b0, dms}, {31'b0, (dm_rd | dm_wr) & ~m.dmd});
        cmp({tag, ".mem_en"},   {31'b0, en},  {31'b0, m.owner != 0});
        cmp({tag, ".mem_we"},   {31'b0, we},  {31'b0, (m.owner == 2) && m.a_we});
        if (m.owner != 0) begin
            cmp({tag, ".mem_addr"},  ad, m.a_addr);
            cmp({tag, ".mem_func3"}, {29'b0, f3}, {29'b0, m.a_f3});
            if (m.owner == 2 && m.a_we) cmp({tag, ".mem_wdata"}, wd, m.a_wdata);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check_inst("lat1", m1, ifv1, ifr1, ifs1, dmd1, dmr1, dms1, en1, we1, ad1, wd1, f31);
            check_inst("lat3", m3, ifv3, ifr3, ifs3, dmd3, dmr3, dms3, en3, we3, ad3, wd3, f33);
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next();
            if_req = 0; dm_rd = 0; dm_wr = 0; if_flush = 0;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        RST = 0; if_req = 1; if_addr = 0; if_flush = 0;
        dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; dm_func3 = 0;

        // reset held two cycles with a pending fetch
        repeat (2) begin
            next(); #4;
            cmp("rst.mem_en1",   {31'b0, en1},  32'd0);
            cmp("rst.if_valid1", {31'b0, ifv1}, 32'd0);
            cmp("rst.if_rdata1", ifr1, NOP);
            cmp("rst.mem_en3",   {31'b0, en3},  32'd0);
            cmp("rst.if_rdata3", ifr3, NOP);
        end

        // fetch only, address 0
        next(); RST = 1; if_req = 1; if_addr = 32'h0; #4;
        cmp("fetch.c0.mem_en", {31'b0, en1}, 32'd0);
        next(); #4;
        cmp("fetch.c1.mem_en",   {31'b0, en1},  32'd1);
        cmp("fetch.c1.mem_addr", ad1, 32'h0);
        cmp("fetch.c1.if_valid", {31'b0, ifv1}, 32'd0);
        cmp("fetch.c1.if_stall", {31'b0, ifs1}, 32'd1);
        next(); #4;
        cmp("fetch.c2.if_valid", {31'b0, ifv1}, 32'd1);
        cmp("fetch.c2.if_rdata", ifr1, 32'h0050_0093);
        cmp("fetch.c2.if_stall", {31'b0, ifs1}, 32'd0);
        idle(8);

        // simultaneous fetch and store: data first
        next(); if_req = 1; if_addr = 32'h40; dm_wr = 1; dm_addr = 32'h100;
        dm_wdata = 32'hDEAD_BEEF; dm_func3 = 3'b010; #4;
        cmp("sw.c0.mem_en", {31'b0, en1}, 32'd0);
        next(); #4;
        cmp("sw.c1.mem_en",    {31'b0, en1}, 32'd1);
        cmp("sw.c1.mem_we",    {31'b0, we1}, 32'd1);
        cmp("sw.c1.mem_addr",  ad1, 32'h100);
        cmp("sw.c1.mem_wdata", wd1, 32'hDEAD_BEEF);
        cmp("sw.c1.mem_func3", {29'b0, f31}, 32'd2);
        cmp("sw.c1.if_stall",  {31'b0, ifs1}, 32'd1);
        cmp("sw.c1.dm_stall",  {31'b0, dms1}, 32'd1);
        next(); #4;
        cmp("sw.c2.dm_done",  {31'b0, dmd1}, 32'd1);
        cmp("sw.c2.dm_stall", {31'b0, dms1}, 32'd0);
        cmp("sw.c2.if_stall", {31'b0, ifs1}, 32'd1);
        next(); dm_wr = 0; #4;
        cmp("sw.c3.if_stall", {31'b0, ifs1}, 32'd1);
        next(); #4;
        cmp("sw.c4.mem_we",   {31'b0, we1}, 32'd0);
        cmp("sw.c4.mem_addr", ad1, 32'h40);
        next(); #4;
        cmp("sw.c5.if_valid", {31'b0, ifv1}, 32'd1);
        cmp("sw.c5.if_rdata", ifr1, 32'h5A5A_0040);
        cmp("sw.c5.if_stall", {31'b0, ifs1}, 32'd0);
        idle(10);

        // starvation: three data grants, then forced fetch
        next(); dm_rd = 1; dm_addr = 32'h200; dm_func3 = 3'b010; if_req = 1; if_addr = 32'h80; #4;
        cmp("starve.c0.mem_en", {31'b0, en1}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            next(); #4;
            cmp($sformatf("starve.c%0d.mem_addr", k), ad1, 32'h200);
            cmp($sformatf("starve.c%0d.mem_we", k), {31'b0, we1}, 32'd0);
        end
        next(); #4;
        cmp("starve.c4.mem_addr", ad1, 32'h80);
        next(); #4;
        cmp("starve.c5.if_valid", {31'b0, ifv1}, 32'd1);
        cmp("starve.c5.if_rdata", ifr1, 32'h5A5A_0080);
        cmp("starve.c5.mem_addr", ad1, 32'h200);
        idle(10);

        // flush during a 3-cycle fetch
        next(); if_req = 1; if_addr = 32'hC0; #4;
        cmp("flush.c0.mem_en", {31'b0, en3}, 32'd0);
        next(); #4;
        cmp("flush.c1.mem_en",   {31'b0, en3}, 32'd1);
        cmp("flush.c1.mem_addr", ad3, 32'hC0);
        next(); if_flush = 1; #4;
        cmp("flush.c2.mem_en", {31'b0, en3}, 32'd1);
        next(); if_flush = 0; if_addr = 32'hE0; #4;
        cmp("flush.c3.mem_en",   {31'b0, en3}, 32'd1);
        cmp("flush.c3.mem_addr", ad3, 32'hC0);
        next(); #4;
        cmp("flush.c4.if_valid", {31'b0, ifv3}, 32'd0);
        cmp("flush.c4.if_rdata", ifr3, NOP);
        cmp("flush.c4.mem_addr", ad3, 32'hE0);
        repeat (2) begin
            next(); #4;
            cmp("flush.c56.if_valid", {31'b0, ifv3}, 32'd0);
        end
        next(); #4;
        cmp("flush.c7.if_valid", {31'b0, ifv3}, 32'd1);
        cmp("flush.c7.if_rdata", ifr3, 32'h5A5A_00E0);
        idle(10);

        // reset in the middle of a 3-cycle load
        next(); dm_rd = 1; dm_addr = 32'h300; dm_func3 = 3'b010; #4;
        cmp("rstmid.c0.mem_en", {31'b0, en3}, 32'd0);
        next(); #4;
        cmp("rstmid.c1.mem_en", {31'b0, en3}, 32'd1);
        next(); RST = 0; #4;
        cmp("rstmid.c2.mem_en", {31'b0, en3}, 32'd1);
        next(); RST = 1; dm_rd = 0; #4;
        cmp("rstmid.c3.mem_en",  {31'b0, en3},  32'd0);
        cmp("rstmid.c3.dm_done", {31'b0, dmd3}, 32'd0);
        repeat (2) begin
            next(); #4;
            cmp("rstmid.c45.dm_done", {31'b0, dmd3}, 32'd0);
            cmp("rstmid.c45.mem_en",  {31'b0, en3},  32'd0);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
